// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Column strobe patterns and row priority encoding live here.
package keypad_pkg;

  localparam int KEY_W = 4;
  localparam logic [3:0] COL_INIT = 4'b1110;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  function automatic logic [3:0] col_pattern(
    input logic [1:0] idx
  );
    logic [7:0] dbl;
    dbl = {COL_INIT, COL_INIT} << idx;
    return dbl[7:4];
  endfunction

  // Lowest-index active-low row wins.
  function automatic logic [1:0] first_low(
    input logic [3:0] rows
  );
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running divider producing the keypad scan tick.
// Tick is high for the one cycle the divider is all ones.
module keypad_tick_gen #(
  parameter int CLK_DIV_W = 12
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [CLK_DIV_W-1:0] div;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div <= '0;
    else      div <= div + 1'b1;
  end

  assign tick = &div;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce.
// One key at a time; other keys are ignored until release.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_DIV_W      = 12,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held
);

  localparam logic [3:0] CNT_LAST =
    4'(DEBOUNCE_TICKS - 1);

  logic [3:0] row_m;
  logic [3:0] row_s;
  logic       tick;

  state_t     state, state_n;
  logic [1:0] col_idx, col_idx_n;
  logic [1:0] cap_row, cap_row_n;
  logic [3:0] cnt, cnt_n;
  logic [KEY_W-1:0] code_n;
  logic       valid_n;
  logic       held_n;
  logic       cap_low;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  keypad_tick_gen #(
    .CLK_DIV_W(CLK_DIV_W)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign cap_low = !row_s[cap_row];
  assign col     = col_pattern(col_idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      cap_row   <= 2'd0;
      cnt       <= 4'd0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      col_idx   <= col_idx_n;
      cap_row   <= cap_row_n;
      cnt       <= cnt_n;
      key_code  <= code_n;
      key_valid <= valid_n;
      key_held  <= held_n;
    end
  end

  always_comb begin
    state_n   = state;
    col_idx_n = col_idx;
    cap_row_n = cap_row;
    cnt_n     = cnt;
    code_n    = key_code;
    valid_n   = 1'b0;
    held_n    = key_held;
    if (tick) begin
      unique case (state)
        SCAN: begin
          if (&row_s) begin
            col_idx_n = col_idx + 1'b1;
          end else begin
            cap_row_n = first_low(row_s);
            cnt_n     = 4'd0;
            state_n   = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!cap_low) begin
            col_idx_n = col_idx + 1'b1;
            state_n   = SCAN;
          end else if (cnt == CNT_LAST) begin
            code_n  = {cap_row, col_idx};
            valid_n = 1'b1;
            held_n  = 1'b1;
            state_n = HELD;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        HELD: begin
          if (!cap_low) begin
            cnt_n   = 4'd0;
            state_n = RELEASE;
          end
        end
        RELEASE: begin
          if (cap_low) begin
            cnt_n = 4'd0;
          end else if (cnt == CNT_LAST) begin
            held_n    = 1'b0;
            col_idx_n = col_idx + 1'b1;
            state_n   = SCAN;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a modelled 4x4 key matrix.
// Expected key codes queue up at press time; a monitor checks each pulse.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  bit pressed [4][4];
  int checks = 0;
  int errors = 0;
  int edges  = 0;
  int exp_q [$];

  always #5 clk = ~clk;

  keypad_scanner #(
    .CLK_DIV_W     (2),
    .DEBOUNCE_TICKS(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // Switch matrix: a closed key pulls its row low while its column strobes.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !col[c]) row[r] = 1'b0;
  end

  // Clock edges since reset release; the scan tick acts every 4th edge.
  always @(posedge clk) begin
    if (!rst) edges = 0;
    else      edges = edges + 1;
  end

  function automatic logic [3:0] col_of(input int i);
    logic [3:0] one;
    one = 4'b0001 << (i % 4);
    return ~one;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 16) begin
        $display("FAIL tick_timeout: got %0d cycles, expected <= 4", n);
        $fatal(1, "tick wait expired");
      end
    end while (edges == 0 || edges % 4 != 0);
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  task automatic release_all();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        pressed[r][c] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst && key_valid) begin
      check("valid_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0)
        check("valid_code", int'(key_code), exp_q.pop_front());
    end
  end

  initial begin
    int r, c, nb, need, n;
    release_all();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col", int'(col), 4'b1110);
    check("rst_code", int'(key_code), 0);
    check("rst_valid", int'(key_valid), 0);
    check("rst_held", int'(key_held), 0);
    rst = 1'b1;

    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("scan_col", int'(col), int'(col_of(edges / 4)));
      check("scan_valid", int'(key_valid), 0);
    end

    pressed[1][2] = 1'b1;
    exp_q.push_back(6);
    wait_ticks(20);
    check("k6_held", int'(key_held), 1);
    check("k6_col", int'(col), 4'b1011);
    check("k6_code", int'(key_code), 6);

    pressed[1][2] = 1'b0;
    wait_tick();
    check("bounce_hi1", int'(key_held), 1);
    pressed[1][2] = 1'b1;
    wait_tick();
    check("bounce_lo", int'(key_held), 1);
    pressed[1][2] = 1'b0;
    wait_tick();
    check("rel_hi1", int'(key_held), 1);
    wait_tick();
    check("rel_hi2", int'(key_held), 1);
    wait_tick();
    check("rel_hi3", int'(key_held), 0);
    check("rel_col", int'(col), 4'b0111);
    check("rel_code", int'(key_code), 6);

    wait_tick();
    check("glitch_pre_col", int'(col), 4'b1110);
    pressed[0][0] = 1'b1;
    wait_tick();
    check("glitch_frozen", int'(col), 4'b1110);
    pressed[0][0] = 1'b0;
    wait_tick();
    check("glitch_col", int'(col), 4'b1101);
    check("glitch_code", int'(key_code), 6);
    check("glitch_held", int'(key_held), 0);
    wait_ticks(4);

    pressed[2][3] = 1'b1;
    pressed[3][3] = 1'b1;
    exp_q.push_back(11);
    wait_ticks(20);
    check("k11_code", int'(key_code), 11);
    check("k11_held", int'(key_held), 1);
    check("k11_col", int'(col), 4'b0111);
    for (int k = 0; k < 4; k++) pressed[0][k] = 1'b1;
    wait_ticks(10);
    check("norollover_held", int'(key_held), 1);
    check("norollover_code", int'(key_code), 11);
    release_all();
    wait_ticks(8);
    check("k11_released", int'(key_held), 0);

    pressed[1][2] = 1'b1;
    n = 0;
    while (col != 4'b1011 && n < 8) begin
      wait_tick();
      n++;
    end
    check("find_col2", int'(col), 4'b1011);
    wait_ticks(2);
    check("deb_frozen", int'(col), 4'b1011);
    rst = 1'b0;
    #1;
    check("midrst_col", int'(col), 4'b1110);
    check("midrst_code", int'(key_code), 0);
    check("midrst_valid", int'(key_valid), 0);
    check("midrst_held", int'(key_held), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(6);
    for (int k = 0; k < 5; k++) begin
      wait_tick();
      check("relatch_wait", int'(key_held), 0);
    end
    wait_tick();
    check("relatch_valid", int'(key_valid), 1);
    check("relatch_held", int'(key_held), 1);
    check("relatch_code", int'(key_code), 6);
    release_all();
    wait_ticks(8);

    for (int it = 0; it < 8; it++) begin
      r = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 3));
      pressed[r][c] = 1'b1;
      exp_q.push_back(r * 4 + c);
      wait_ticks(int'($urandom_range(10, 16)));
      check("rnd_held", int'(key_held), 1);
      check("rnd_code", int'(key_code), r * 4 + c);
      check("rnd_col", int'(col), int'(col_of(c)));
      nb = int'($urandom_range(0, 2));
      for (int b = 0; b < nb; b++) begin
        pressed[r][c] = 1'b0;
        wait_ticks(int'($urandom_range(1, 2)));
        check("rnd_bounce_hi", int'(key_held), 1);
        pressed[r][c] = 1'b1;
        wait_tick();
        check("rnd_bounce_lo", int'(key_held), 1);
      end
      // From HELD the first high tick only starts the release count.
      need = (nb == 0) ? 4 : 3;
      pressed[r][c] = 1'b0;
      wait_ticks(need - 1);
      check("rnd_rel_pending", int'(key_held), 1);
      wait_tick();
      check("rnd_rel_done", int'(key_held), 0);
      check("rnd_rel_col", int'(col), int'(col_of(c + 1)));
      wait_ticks(2);
    end

    check("all_presses_seen", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
